// File: rtl/accel_cond_pkg.sv
// Shared types and width helpers for the accelerometer sample conditioner.
package accel_cond_pkg;

    typedef enum logic [1:0] {
        StCal,
        StCalFin,
        StRun
    } state_e;

    localparam int unsigned DEF_GAIN     = 598550;
    localparam int unsigned DEF_W_IN     = 16;
    localparam int unsigned DEF_CAL_LOG2 = 4;
    localparam int unsigned DEF_AVG_LOG2 = 2;

    // Calibration accumulator: raw width plus headroom for 2^cal_log2 samples.
    function automatic int unsigned acc_width(int unsigned w_in, int unsigned cal_log2);
        return w_in + cal_log2;
    endfunction

    // Running sum: bias-removed width (w_in+1) plus headroom for 2^avg_log2 taps.
    function automatic int unsigned sum_width(int unsigned w_in, int unsigned avg_log2);
        return w_in + 1 + avg_log2;
    endfunction

endpackage

// File: rtl/accel_sample_conditioner_if.sv
// Raw sample valid/ready channel into the conditioner.
interface accel_sample_conditioner_if #(
    parameter int unsigned W_IN = 16
) ();
    logic                   raw_valid;
    logic                   raw_ready;
    logic signed [W_IN-1:0] raw_data;

    modport master (output raw_valid, output raw_data, input raw_ready);
    modport slave  (input raw_valid, input raw_data, output raw_ready);
endinterface

// File: rtl/accel_sample_conditioner_moving_average.sv
// Ring buffer plus exact running sum over the last 2^DEPTH_LOG2 inputs.
module moving_average #(
    parameter int unsigned D_W        = 17,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic                            clear,
    input  logic                            in_valid,
    input  logic signed [D_W-1:0]           din,
    output logic signed [D_W+DEPTH_LOG2-1:0] sum
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = D_W + DEPTH_LOG2;

    logic signed [D_W-1:0]   ring_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] din_ext;
    logic signed [SUM_W-1:0] oldest_ext;

    assign din_ext    = {{DEPTH_LOG2{din[D_W-1]}}, din};
    assign oldest_ext = {{DEPTH_LOG2{ring_q[wr_ptr_q][D_W-1]}}, ring_q[wr_ptr_q]};
    assign sum        = sum_q;

    // Replace the oldest entry and adjust the sum by the difference.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
        end else if (in_valid) begin
            ring_q[wr_ptr_q] <= din;
            sum_q            <= sum_q + din_ext - oldest_ext;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/accel_sample_conditioner.sv
// Accelerometer front end: bias calibration, bias removal, moving average and
// scaling to nano-units. Define DEADBAND_EN to zero small bias-removed samples.
module accel_sample_conditioner
    import accel_cond_pkg::*;
#(
    parameter int unsigned N        = 64,
    parameter int unsigned W_IN     = DEF_W_IN,
    parameter int unsigned CAL_LOG2 = DEF_CAL_LOG2,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
`ifdef DEADBAND_EN
    parameter int unsigned DEADBAND = 8,
`endif
    parameter int unsigned GAIN     = DEF_GAIN
) (
    input  logic                  clk,
    input  logic                  resetb,
    accel_sample_conditioner_if.slave raw,
    input  logic                  recal,
    output logic signed [N-1:0]   signal_out,
    output logic                  sample_strobe,
    output logic                  cal_done
);
    localparam int unsigned ACC_W = acc_width(W_IN, CAL_LOG2);
    localparam int unsigned SUM_W = sum_width(W_IN, AVG_LOG2);
    localparam int unsigned D_W   = W_IN + 1;

    state_e                  state_q, state_d;
    logic                    accept;
    logic signed [ACC_W-1:0] acc_q;
    logic [CAL_LOG2-1:0]     cal_cnt_q;
    logic signed [W_IN-1:0]  bias_q;
    logic signed [D_W-1:0]   d_raw, d_s1, d_q;
    logic                    v1_q, v2_q, fire_s3;
    logic signed [SUM_W-1:0] ma_sum;
    logic signed [D_W-1:0]   avg;
    logic signed [N-1:0]     avg_ext, gain_n, product;

    assign raw.raw_ready = (state_q != StCalFin) & ~recal & ~resetb;
    assign accept        = raw.raw_valid & raw.raw_ready;
    assign cal_done      = (state_q == StRun);

    // Next-state: recal overrides everything and restarts calibration.
    always_comb begin
        state_d = state_q;
        if (recal) begin
            state_d = StCal;
        end else begin
            case (state_q)
                StCal:    if (accept && (cal_cnt_q == '1)) state_d = StCalFin;
                StCalFin: state_d = StRun;
                StRun:    state_d = StRun;
                default:  state_d = StCal;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) state_q <= StCal;
        else        state_q <= state_d;
    end

    // Calibration accumulate; bias is the floored mean taken in CAL_FIN.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            acc_q     <= '0;
            cal_cnt_q <= '0;
            bias_q    <= '0;
        end else if (recal) begin
            acc_q     <= '0;
            cal_cnt_q <= '0;
        end else if ((state_q == StCal) && accept) begin
            acc_q     <= acc_q + {{CAL_LOG2{raw.raw_data[W_IN-1]}}, raw.raw_data};
            cal_cnt_q <= cal_cnt_q + 1'b1;
        end else if (state_q == StCalFin) begin
            bias_q <= acc_q[ACC_W-1:CAL_LOG2];
            acc_q  <= '0;
        end
    end

    assign d_raw = {raw.raw_data[W_IN-1], raw.raw_data} - {bias_q[W_IN-1], bias_q};

`ifdef DEADBAND_EN
    localparam logic signed [D_W-1:0] DB_POS = D_W'(DEADBAND);
    localparam logic signed [D_W-1:0] DB_NEG = -DB_POS;
    assign d_s1 = ((d_raw <= DB_POS) && (d_raw >= DB_NEG)) ? '0 : d_raw;
`else
    assign d_s1 = d_raw;
`endif

    // S1: register the bias-removed sample for samples accepted in RUN.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            v1_q <= 1'b0;
            d_q  <= '0;
        end else begin
            v1_q <= accept & (state_q == StRun);
            if (accept) d_q <= d_s1;
        end
    end

    // S2: ring buffer and running sum; an in-flight sample is dropped on recal.
    moving_average #(
        .D_W        (D_W),
        .DEPTH_LOG2 (AVG_LOG2)
    ) u_moving_average (
        .clk      (clk),
        .resetb   (resetb),
        .clear    (state_q == StCalFin),
        .in_valid (v1_q & ~recal),
        .din      (d_q),
        .sum      (ma_sum)
    );

    // S2 valid tracks the sample now held in the running sum.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) v2_q <= 1'b0;
        else        v2_q <= v1_q & ~recal;
    end

    assign avg     = ma_sum[SUM_W-1:AVG_LOG2];
    assign avg_ext = {{(N-D_W){avg[D_W-1]}}, avg};
    assign gain_n  = N'(GAIN);
    assign product = avg_ext * gain_n;
    assign fire_s3 = v2_q & ~recal;

    // S3: scale and publish; output holds its value between strobes.
    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            signal_out    <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= fire_s3;
            if (fire_s3) signal_out <= product;
        end
    end
endmodule

// File: tb/tb_accel_sample_conditioner.sv
// Randomised bench for accel_sample_conditioner with a queue-based reference model.
module tb_accel_sample_conditioner;
    localparam longint GAIN = 598550;

    logic               clk;
    logic               resetb;
    logic               recal;
    logic signed [63:0] signal_out;
    logic               sample_strobe;
    logic               cal_done;

    accel_sample_conditioner_if #(.W_IN(16)) bus ();

    accel_sample_conditioner dut (
        .clk           (clk),
        .resetb        (resetb),
        .raw           (bus),
        .recal         (recal),
        .signal_out    (signal_out),
        .sample_strobe (sample_strobe),
        .cal_done      (cal_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_CAL, M_FIN, M_RUN} mode_e;
    typedef struct {
        int     due;
        longint val;
    } pend_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc;
    mode_e  m_mode;
    int     m_cnt;
    longint m_acc, m_bias, last_val;
    longint m_ring[$];
    pend_t  pend[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc,
                     $signed(act), $signed(exp));
        end
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    // Reference behaviour at the clock edge ending cycle 'cyc'.
    task automatic model_edge(input bit acc, input longint x, input bit rc);
        longint d, s;
        if (rc) begin
            m_mode = M_CAL;
            m_cnt  = 0;
            m_acc  = 0;
            pend.delete();
        end else begin
            case (m_mode)
                M_CAL: if (acc) begin
                    m_acc += x;
                    m_cnt++;
                    if (m_cnt == 16) m_mode = M_FIN;
                end
                M_FIN: begin
                    m_bias = fdiv(m_acc, 16);
                    m_ring.delete();
                    repeat (4) m_ring.push_back(0);
                    m_mode = M_RUN;
                end
                default: if (acc) begin
                    d = x - m_bias;
`ifdef DEADBAND_EN
                    if (d <= 8 && d >= -8) d = 0;
`endif
                    void'(m_ring.pop_front());
                    m_ring.push_back(d);
                    s = 0;
                    foreach (m_ring[i]) s += m_ring[i];
                    pend.push_back('{due: cyc + 3, val: fdiv(s, 4) * GAIN});
                end
            endcase
        end
    endtask

    task automatic cycle(input bit v, input logic signed [15:0] x, input bit rc);
        bit exp_stb, exp_rdy;
        @(negedge clk);
        exp_stb = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_stb  = 1'b1;
            last_val = pend[0].val;
            void'(pend.pop_front());
        end
        check("sample_strobe", 64'(sample_strobe), 64'(exp_stb));
        check("signal_out", signal_out, last_val);
        check("cal_done", 64'(cal_done), 64'(m_mode == M_RUN));
        bus.raw_valid = v;
        bus.raw_data  = x;
        recal         = rc;
        #1;
        exp_rdy = (m_mode != M_FIN) && !rc;
        check("raw_ready", 64'(bus.raw_ready), 64'(exp_rdy));
        model_edge(v && exp_rdy, longint'(x), rc);
        cyc++;
    endtask

    // Asserts reset leaving raw_valid as it is, checks outputs clear at once.
    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b1;
        #1;
        check("rst_signal_out", signal_out, 64'd0);
        check("rst_strobe", 64'(sample_strobe), 64'd0);
        check("rst_cal_done", 64'(cal_done), 64'd0);
        check("rst_raw_ready", 64'(bus.raw_ready), 64'd0);
        @(negedge clk);
        bus.raw_valid = 1'b0;
        recal         = 1'b0;
        resetb        = 1'b0;
        m_mode   = M_CAL;
        m_cnt    = 0;
        m_acc    = 0;
        m_bias   = 0;
        last_val = 0;
        pend.delete();
        cyc = 1;
    endtask

    task automatic feed(input int n, input logic signed [15:0] x);
        for (int i = 0; i < n; i++) cycle(1'b1, x, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'sd0, 1'b0);
    endtask

    initial begin
        logic signed [15:0] r;
        resetb        = 1'b1;
        recal         = 1'b0;
        bus.raw_valid = 1'b0;
        bus.raw_data  = '0;
        cyc           = 0;
        do_reset();

        // Calibrate on 100, then a steady 104 (d = 4) with its ramp.
        feed(16, 16'sd100);
        feed(12, 16'sd104);
        idle(4);

        // Recalibrate on -37, feed -37 then -30.
        cycle(1'b0, 16'sd0, 1'b1);
        feed(16, -16'sd37);
        feed(6, -16'sd37);
        feed(8, -16'sd30);
        idle(4);

        // Two samples in flight when recal arrives, with raw_valid held high.
        feed(2, 16'sd500);
        cycle(1'b1, 16'sd500, 1'b1);
        idle(3);

        // Alternating +1/-2 calibration, then wrap the ring.
        for (int i = 0; i < 16; i++) cycle(1'b1, (i % 2 == 0) ? 16'sd1 : -16'sd2, 1'b0);
        feed(1, 16'sd0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 16'(i * 37 - 90), 1'b0);
        idle(4);

        // Random traffic with gaps and occasional recal.
        for (int i = 0; i < 600; i++) begin
            r = 16'($urandom);
            cycle(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 79) == 0));
        end
        idle(4);

        // Reset in the middle of RUN with raw_valid held.
        cycle(1'b0, 16'sd0, 1'b1);
        feed(16, 16'sd12);
        feed(5, 16'sd900);
        bus.raw_valid = 1'b1;
        do_reset();
        feed(16, -16'sd5);
        feed(6, 16'sd200);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
